pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf_pkg.sv | 34 +++
 rtl/pipe_stage_buf_entry.sv | 46 ++++
 rtl/pipe_stage_buf.sv | 139 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf_pkg
//   Shared definitions for the pipeline stage buffer:
//     - buf_state_e      : occupancy state encoding (EMPTY=0, ONE=1, FULL=2)
//     - PIPE_MAX_WIDTH   : widest payload the stage buffer supports
//     - PIPE_NOP_DEFAULT : default bubble value (all zeros), sliced to WIDTH
//     - ENTRY_COUNT, HEAD_IDX, SKID_IDX : storage slot layout
//     - state_count()    : occupancy derived from the state encoding
// ---------------------------------------------------------------------------
package pipe_stage_buf_pkg;

  // The encoding doubles as the occupancy count, so count is just the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam int unsigned PIPE_MAX_WIDTH = 128;

  // Bubble value presented when nothing is held; users slice [WIDTH-1:0].
  localparam logic [PIPE_MAX_WIDTH-1:0] PIPE_NOP_DEFAULT = '0;

  // Slot 0 always holds the oldest word (head); slot 1 catches the word that
  // arrives while the head is stalled (skid).
  localparam int unsigned ENTRY_COUNT = 2;
  localparam int unsigned HEAD_IDX    = 0;
  localparam int unsigned SKID_IDX    = 1;

  function automatic logic [1:0] state_count(input buf_state_e s);
    return s;
  endfunction

endpackage : pipe_stage_buf_pkg

// File: rtl/pipe_stage_buf_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
//   WIDTH-bit load-enable register with synchronous active-low reset.
//   Used for the head and skid slots of pipe_stage_buf.
//
//   Ports:
//     clk_i   : clock, rising-edge
//     rst_ni  : synchronous active-low reset, loads RST_VALUE
//     load_i  : capture d_i at the next rising edge
//     d_i     : data to capture
//     q_o     : stored data
// ---------------------------------------------------------------------------
module pipe_entry_reg
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RST_VALUE = PIPE_NOP_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= RST_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : pipe_entry_reg

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//   Two-entry in-order skid buffer used as a drop-in pipeline register
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). One cycle of latency, full throughput,
//   and in_ready depends only on registered state (plus R and flush), so
//   no combinational path exists from out_ready back to in_ready.
//
//   Parameters:
//     WIDTH     : payload width, 1..128
//     NOP_VALUE : value on out_data while the buffer is empty
//
//   Ports:
//     Clk       : clock, rising-edge
//     R         : synchronous active-low reset
//     in_valid  : upstream word present on in_data
//     in_ready  : buffer accepts a word this cycle
//     in_data   : upstream payload
//     out_valid : out_data holds a real entry
//     out_ready : downstream consumes out_data this cycle
//     out_data  : head entry, or NOP_VALUE when empty
//     flush     : squash every held entry
//     count     : occupancy 0..2
// ---------------------------------------------------------------------------
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = PIPE_NOP_DEFAULT[WIDTH-1:0]
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  buf_state_e state_q;
  buf_state_e state_d;

  logic [WIDTH-1:0] entry_q    [ENTRY_COUNT];
  logic [WIDTH-1:0] entry_d    [ENTRY_COUNT];
  logic             entry_load [ENTRY_COUNT];

  logic push;
  logic pop;

  // ---------------------------------------------------------------------
  // Storage slots
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < ENTRY_COUNT; gi++) begin : g_entry
    pipe_entry_reg #(
      .WIDTH     (WIDTH),
      .RST_VALUE (NOP_VALUE)
    ) u_entry (
      .clk_i  (Clk),
      .rst_ni (R),
      .load_i (entry_load[gi]),
      .d_i    (entry_d[gi]),
      .q_o    (entry_q[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  // R is folded in so upstream sees a stall for the whole reset cycle.
  assign in_ready  = R && (state_q != ST_FULL) && !flush;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? entry_q[HEAD_IDX] : NOP_VALUE;
  assign count     = state_count(state_q);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // ---------------------------------------------------------------------
  // Next-state and slot load control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d              = state_q;
    entry_load[HEAD_IDX] = 1'b0;
    entry_load[SKID_IDX] = 1'b0;
    entry_d[HEAD_IDX]    = in_data;
    entry_d[SKID_IDX]    = in_data;

    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d              = ST_ONE;
          entry_load[HEAD_IDX] = 1'b1;
        end
      end

      ST_ONE: begin
        if (push && pop) begin
          // Head leaves as the new word arrives: new word becomes head.
          entry_load[HEAD_IDX] = 1'b1;
        end else if (push) begin
          state_d              = ST_FULL;
          entry_load[SKID_IDX] = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // No push is possible here because in_ready is low.
        if (pop) begin
          state_d              = ST_ONE;
          entry_load[HEAD_IDX] = 1'b1;
          entry_d[HEAD_IDX]    = entry_q[SKID_IDX];
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Squash: any pop this cycle has already been taken downstream, and
    // in_ready is low so nothing new was accepted.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge Clk) begin
    if (!R) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Scoreboard bench for pipe_stage_buf (WIDTH=16, NOP_VALUE=0).
//   The reference is a plain queue of accepted words (capacity 2): the
//   model process appends accepted words at each rising edge, the monitor
//   compares DUT outputs against the queue mid-cycle and retires the head
//   whenever the model says a pop happens.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam int unsigned W   = 16;
  localparam logic [W-1:0] NOP = 16'h0000;

  logic         Clk;
  logic         R;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   count;

  pipe_stage_buf #(
    .WIDTH     (W),
    .NOP_VALUE (NOP)
  ) dut (
    .Clk       (Clk),
    .R         (R),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference contents, oldest first.
  logic [W-1:0] exp_q [$];
  logic         exp_ready_s;
  int           total_cnt;
  int           pass_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // One stimulus cycle: inputs change just after the rising edge and hold
  // until the next one.
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic r);
    @(posedge Clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    R         = r;
  endtask

  // Model update at the edge: reset and flush empty the buffer, otherwise
  // an accepted word joins the tail. Pops were already retired mid-cycle.
  always @(posedge Clk) begin
    if (!R || flush) begin
      exp_q.delete();
    end else if (in_valid && exp_ready_s) begin
      exp_q.push_back(in_data);
    end
  end

  // Monitor: mid-cycle, inputs and outputs are stable.
  always @(negedge Clk) begin
    int           sz;
    logic [W-1:0] exp_head;
    sz          = exp_q.size();
    exp_head    = (sz > 0) ? exp_q[0] : NOP;
    exp_ready_s = R && (sz < 2) && !flush;

    chk("count",     32'(count),     32'(sz));
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("in_ready",  32'(in_ready),  32'(exp_ready_s));
    chk("out_data",  32'(out_data),  32'(exp_head));

    if (sz > 0 && out_ready && R) begin
      $display("pop  data=%h t=%0t", exp_head, $time);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    R           = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    exp_ready_s = 1'b0;
    total_cnt   = 0;
    pass_cnt    = 0;

    // Reset
    drive(0, 16'h0, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 1);

    // Streaming with downstream always ready
    for (int i = 1; i <= 4; i++) begin
      drive(1, 16'hA000 + 16'(i), 1, 0, 1);
    end
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);

    // Skid: fill with downstream stalled, then drain
    drive(1, 16'hA001, 0, 0, 1);
    drive(1, 16'hA002, 0, 0, 1);
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);

    // Flush while full, with a word offered in the same cycle
    drive(1, 16'hB001, 0, 0, 1);
    drive(1, 16'hB002, 0, 0, 1);
    drive(1, 16'hBEEF, 0, 1, 1);
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);

    // Simultaneous push and pop while holding one word
    drive(1, 16'h1111, 0, 0, 1);
    drive(1, 16'h2222, 1, 0, 1);
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);

    // Reset while full
    drive(1, 16'hD001, 0, 0, 1);
    drive(1, 16'hD002, 0, 0, 1);
    drive(0, 16'h0, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 1, 0, 1);

    // Head held stable across a 5-cycle stall
    drive(1, 16'hC0DE, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 16'h0, 0, 0, 1);
    end
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
    end

    // Drain and let the last mid-cycle checks happen
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);
    drive(0, 16'h0, 1, 0, 1);
    @(negedge Clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pipe_stage_buf
